// File: rtl/mmss_display_pkg.sv
// Shared constants and types for the MM.SS 7-segment display driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package mmss_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef logic [1:0] digit_idx_t;

  // Digit to segment code; anything outside 0..9 shows as blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/mmss_bcd_split.sv
// Binary 0..127 to two BCD digits, saturating at 99.
module mmss_bcd_split (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] clamped;

  // Saturate, then split into tens/ones by constant division.
  always_comb begin
    clamped = (bin > 7'd99) ? 7'd99 : bin;
    tens    = 4'(clamped / 7'd10);
    ones    = 4'(clamped % 7'd10);
  end

endmodule

// File: rtl/mmss_display_driver.sv
// Four-digit common-anode multiplexed display showing MM.SS.
// Optional feature macro: MMSS_DISPLAY_BLINK_EN blinks the display while the
// captured time is 00:00.
module mmss_display_driver
  import mmss_display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] minutes,
  input  logic [6:0] seconds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
    $error("mmss_display_driver: SCAN_DIV and BLINK_DIV must be >= 2");
  end

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [6:0]    snap_min, snap_sec;
  logic [6:0]    snap_min_n, snap_sec_n;
  logic          active;
  logic          presc_tc;
  logic          frame_start;
  logic          blank_all;

  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  assign presc_tc    = (presc == PW'(SCAN_DIV - 1));
  // A frame begins whenever digit 0 starts with a fresh prescaler, which also
  // covers the first enabled cycle since both are held at zero while disabled.
  assign frame_start = enable && (idx == 2'd0) && (presc == '0);

  // The capture value is forwarded so the first digit-0 cycle of a frame
  // already shows the new snapshot.
  assign snap_min_n = frame_start ? minutes : snap_min;
  assign snap_sec_n = frame_start ? seconds : snap_sec;

  mmss_bcd_split u_split_min (.bin(snap_min_n), .tens(min_tens), .ones(min_ones));
  mmss_bcd_split u_split_sec (.bin(snap_sec_n), .tens(sec_tens), .ones(sec_ones));

  // Scan prescaler, digit index, frame snapshot and enable history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      idx      <= 2'd0;
      snap_min <= 7'd0;
      snap_sec <= 7'd0;
      active   <= 1'b0;
    end else begin
      active <= enable;
      if (!enable) begin
        presc <= '0;
        idx   <= 2'd0;
      end else begin
        snap_min <= snap_min_n;
        snap_sec <= snap_sec_n;
        if (presc_tc) begin
          presc <= '0;
          idx   <= idx + 2'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

`ifdef MMSS_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink;

  // Blink half-period timer; restarts dark-free whenever the display is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!enable) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank_all = blink && (snap_min_n == 7'd0) && (snap_sec_n == 7'd0);
`else
  assign blank_all = 1'b0;
`endif

  // Next pin values for the current digit index.
  always_comb begin
    an_n  = ~(4'b0001 << idx);
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    unique case (idx)
      2'd0: seg_n = seg_of(sec_ones);
      2'd1: seg_n = seg_of(sec_tens);
      2'd2: begin
        seg_n = seg_of(min_ones);
        dp_n  = 1'b0;
      end
      2'd3: seg_n = (min_tens == 4'd0) ? SEG_BLANK : seg_of(min_tens);
      default: seg_n = SEG_BLANK;
    endcase
  end

  // Pins update together on one edge so no anode sees a stale segment pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (!enable || !active) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= blank_all ? AN_OFF : an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule

// File: tb/tb_mmss_display_driver.sv
// Directed bench for mmss_display_driver with SCAN_DIV=4, BLINK_DIV=20.
// Expected digit slots are queued as inputs are driven and checked as the
// display scans through them.
module tb_mmss_display_driver;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t sb[$];

  logic [6:0] ref_seg [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  mmss_display_driver #(.SCAN_DIV(4), .BLINK_DIV(20)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .minutes(minutes), .seconds(seconds),
    .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] ea,
                       input logic [6:0] es, input logic ed);
    total++;
    assert ({an, seg, dp} === {ea, es, ed})
    else begin
      bad++;
      $error("FAIL %s: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
             tag, an, seg, dp, ea, es, ed);
    end
  endtask

  // Queue the expected pins for digit slot i showing m:s.
  task automatic push_slot(input int i, input int m, input int s);
    int    mc, sc;
    slot_t e;
    mc = (m > 99) ? 99 : m;
    sc = (s > 99) ? 99 : s;
    e.dp = 1'b1;
    case (i)
      0: begin e.an = 4'b1110; e.seg = ref_seg[sc % 10]; end
      1: begin e.an = 4'b1101; e.seg = ref_seg[sc / 10]; end
      2: begin e.an = 4'b1011; e.seg = ref_seg[mc % 10]; e.dp = 1'b0; end
      default: begin
        e.an  = 4'b0111;
        e.seg = (mc / 10 == 0) ? 7'h7F : ref_seg[mc / 10];
      end
    endcase
    sb.push_back(e);
  endtask

  task automatic push_frame(input int m, input int s);
    for (int i = 0; i < 4; i++) push_slot(i, m, s);
  endtask

  // Each queued slot must hold for four cycles starting at the current negedge.
  task automatic run_slots(input int n, input string tag);
    slot_t e;
    for (int j = 0; j < n; j++) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s: scoreboard empty, want a queued slot", tag);
        return;
      end
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
        check(tag, e.an, e.seg, e.dp);
        step();
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    minutes = 7'd0;
    seconds = 7'd0;
    step();
    check("reset", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b1;
    step();
    check("idle_disabled", 4'b1111, 7'h7F, 1'b1);

    // 5:00 from a cold enable: dark for one cycle, then digit 0.
    minutes = 7'd5;
    seconds = 7'd0;
    enable  = 1'b1;
    step();
    check("first_enable_dark", 4'b1111, 7'h7F, 1'b1);
    step();
    check("first_digit0", 4'b1110, 7'h40, 1'b1);
    step();
    step();
    step();
    for (int i = 1; i < 4; i++) push_slot(i, 5, 0);
    push_slot(0, 5, 0);
    run_slots(4, "frame_5_00");

    // 25:59 appears only at the next frame boundary.
    minutes = 7'd25;
    seconds = 7'd59;
    for (int i = 1; i < 4; i++) push_slot(i, 5, 0);
    push_frame(25, 59);
    push_slot(0, 25, 59);
    push_slot(1, 25, 59);
    run_slots(9, "frame_25_59");

    // Mid-frame change during idx2 must not tear the current frame.
    seconds = 7'd58;
    push_slot(2, 25, 59);
    push_slot(3, 25, 59);
    push_frame(25, 58);
    run_slots(6, "no_tearing");

    // Clamp: 120:75 -> 99.75.
    minutes = 7'd120;
    seconds = 7'd75;
    push_frame(25, 58);
    push_frame(120, 75);
    push_slot(0, 120, 75);
    push_slot(1, 120, 75);
    run_slots(10, "clamp_99_75");

    // Drop enable in the middle of idx2.
    check("idx2_before_disable", 4'b1011, 7'h10, 1'b0);
    step();
    enable = 1'b0;
    step();
    check("disable_next_edge", 4'b1111, 7'h7F, 1'b1);
    step();
    check("disabled_hold", 4'b1111, 7'h7F, 1'b1);

    // Re-enable with 3:07; digit 0 two cycles later.
    minutes = 7'd3;
    seconds = 7'd7;
    enable  = 1'b1;
    step();
    check("reenable_dark", 4'b1111, 7'h7F, 1'b1);
    step();
    check("reenable_digit0", 4'b1110, 7'h78, 1'b1);
    step();
    check("reenable_digit0_hold", 4'b1110, 7'h78, 1'b1);
    step();
    check("reenable_digit0_hold", 4'b1110, 7'h78, 1'b1);
    step();
    for (int i = 1; i < 4; i++) push_slot(i, 3, 7);
    push_slot(0, 3, 7);
    run_slots(4, "frame_3_07");

    // Seconds above 59 shown verbatim, non-zero minutes tens.
    minutes = 7'd10;
    seconds = 7'd60;
    for (int i = 1; i < 4; i++) push_slot(i, 3, 7);
    push_frame(10, 60);
    run_slots(7, "frame_10_60");

    // Expired timer 00:00.
    minutes = 7'd0;
    seconds = 7'd0;
    push_frame(10, 60);
    run_slots(4, "frame_10_60_tail");
`ifdef MMSS_DISPLAY_BLINK_EN
    begin
      int dark;
      dark = 0;
      repeat (40) step();
      for (int k = 0; k < 80; k++) begin
        if (an === 4'b1111) dark++;
        step();
      end
      total++;
      assert (dark == 40)
      else begin
        bad++;
        $error("FAIL blink_dark_cycles: got %0d dark cycles of 80, want 40", dark);
      end
    end
`else
    push_frame(0, 0);
    push_frame(0, 0);
    run_slots(8, "steady_0_00");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
